// File: rtl/ds_pkg.sv
// ds_pkg: shared types and helpers for the delta-sigma sample sequencer.
//   ds_seq_state_t : playback state (IDLE, PRIME, RUN, STARVE)
//   midscale()     : mid-scale code for an unsigned sample of a given width
package ds_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        RUN    = 2'd2,
        STARVE = 2'd3
    } ds_seq_state_t;

    // 1 << (bits-1): the value the modulator sees when there is no audio.
    function automatic logic [31:0] midscale(input int bits);
        return 32'd1 << (bits - 1);
    endfunction

endpackage

// File: rtl/ds_sample_fifo.sv
// ds_sample_fifo: synchronous sample FIFO with flush.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   i_flush       drop all contents (wins over push/pop in the same cycle)
//   i_push        write i_wdata if not full
//   i_pop         advance read pointer if not empty
//   o_rdata       head of FIFO (valid when !o_empty)
//   o_full/o_empty/o_fill  occupancy status, o_fill in 0..DEPTH
module ds_sample_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 8
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_wdata,
    output logic [W-1:0]             o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_fill
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_fill;
    logic          w_push;
    logic          w_pop;

    // Push is judged against the current fill, so a full FIFO refuses a
    // push even when a pop frees a slot in the same cycle.
    assign w_push = i_push && !o_full  && !i_flush;
    assign w_pop  = i_pop  && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Storage needs no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_fill == FULL_LVL);
    assign o_empty = (r_fill == '0);
    assign o_fill  = r_fill;

endmodule

// File: rtl/delta_sigma_sequencer.sv
// delta_sigma_sequencer: buffers PCM samples and paces the delta-sigma
// modulator, presenting a new sample every OSR ena strobes, one strobe
// every ENA_DIV clocks.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   start / stop      playback control pulses (stop wins)
//   s_valid/s_data/s_ready   sample input handshake
//   ds_ena / ds_in    modulator strobe and sample
//   underrun          one-cycle pulse: FIFO empty at a frame boundary in RUN
//   busy              state != IDLE
//   fill              FIFO occupancy
// Optional: define DS_SEQ_STATS_EN to add underrun_cnt[15:0], a saturating
// underrun counter cleared by reset and by start.
module delta_sigma_sequencer
    import ds_pkg::*;
#(
    parameter int IN_BITS    = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int OSR        = 64,
    parameter int ENA_DIV    = 4
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         s_valid,
    input  logic [IN_BITS-1:0]           s_data,
    output logic                         s_ready,
    output logic                         ds_ena,
    output logic [IN_BITS-1:0]           ds_in,
    output logic                         underrun,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fill
`ifdef DS_SEQ_STATS_EN
    ,
    output logic [15:0]                  underrun_cnt
`endif
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int DIV_W = $clog2(ENA_DIV);
    localparam int OSR_W = $clog2(OSR);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(ENA_DIV - 1);
    localparam logic [OSR_W-1:0]   OSR_LAST = OSR_W'(OSR - 1);
    localparam logic [AW:0]        HALF     = (AW+1)'(FIFO_DEPTH / 2);
    localparam logic [IN_BITS-1:0] MID      = IN_BITS'(midscale(IN_BITS));

    ds_seq_state_t      r_state;
    ds_seq_state_t      w_state_nxt;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [OSR_W-1:0]   r_osr_cnt;
    logic [IN_BITS-1:0] r_ds_in;
    logic [IN_BITS-1:0] w_head;
    logic [AW:0]        w_fill;
    logic               w_full;
    logic               w_empty;
    logic               w_half;
    logic               w_active;
    logic               w_ena;
    logic               w_bnd;
    logic               w_pop;
    logic               w_underrun;

    ds_sample_fifo #(
        .W     (IN_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (stop),
        .i_push  (s_valid),
        .i_pop   (w_pop),
        .i_wdata (s_data),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_fill  (w_fill)
    );

    assign w_half   = (w_fill >= HALF);
    assign w_active = (r_state == RUN) || (r_state == STARVE);
    assign w_ena    = w_active && (r_div_cnt == DIV_LAST);
    assign w_bnd    = w_ena && (r_osr_cnt == OSR_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_underrun  = 1'b0;
        case (r_state)
            IDLE:   if (start) w_state_nxt = PRIME;
            PRIME:  if (w_half) begin
                        w_pop       = 1'b1;
                        w_state_nxt = RUN;
                    end
            RUN:    if (w_bnd) begin
                        // Emptiness is judged before any same-cycle push:
                        // no bypass path into ds_in.
                        if (!w_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            w_underrun  = 1'b1;
                            w_state_nxt = STARVE;
                        end
                    end
            STARVE: if (w_bnd && w_half) begin
                        w_pop       = 1'b1;
                        w_state_nxt = RUN;
                    end
            default: w_state_nxt = IDLE;
        endcase
        if (stop) begin
            w_state_nxt = IDLE;
            w_pop       = 1'b0;
            w_underrun  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Strobe divider and oversampling counter; idle at 0 outside RUN/STARVE
    // so the first strobe lands ENA_DIV-1 cycles into RUN.
    always_ff @(posedge clk) begin
        if (!rst || stop || !w_active) begin
            r_div_cnt <= '0;
            r_osr_cnt <= '0;
        end else begin
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
            if (w_ena)
                r_osr_cnt <= (r_osr_cnt == OSR_LAST) ? '0 : r_osr_cnt + 1'b1;
        end
    end

    // Popped sample lands one cycle after the boundary, well before the
    // next strobe since ENA_DIV >= 2.
    always_ff @(posedge clk) begin
        if (!rst || stop) r_ds_in <= MID;
        else if (w_pop)   r_ds_in <= w_head;
    end

`ifdef DS_SEQ_STATS_EN
    logic [15:0] r_ucnt;
    always_ff @(posedge clk) begin
        if (!rst)                                   r_ucnt <= '0;
        else if (start && !stop)                    r_ucnt <= '0;
        else if (w_underrun && r_ucnt != 16'hFFFF)  r_ucnt <= r_ucnt + 1'b1;
    end
    assign underrun_cnt = r_ucnt;
`endif

    assign s_ready  = !w_full;
    assign ds_ena   = w_ena;
    assign ds_in    = r_ds_in;
    assign underrun = w_underrun;
    assign busy     = (r_state != IDLE);
    assign fill     = w_fill;

endmodule
